// File: rtl/seg7_decoder.sv
// seg7_decoder
//   Recovers a hex digit (0-F) from an active-low seven-segment pattern.
//   A pattern must be sampled STABLE_CYCLES times in a row (qualified by
//   sample_en) before a decision is taken.
//
//   Each decision is one of three kinds:
//     - legal pattern   -> decoded value, valid set
//     - blank (7F)      -> valid and err both cleared
//     - illegal pattern -> err set, and err_count increments (saturating)
//
// Parameters
//   STABLE_CYCLES : consecutive qualified samples per decision (1..255)
//   ERR_W         : width of the saturating illegal-pattern counter
//
// Ports
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   hex_in    : segment pattern, active-low, bit0=a .. bit6=g
//   sample_en : sample qualifier; when low all state freezes
//   value     : last successfully decoded digit
//   valid     : value holds a legal, stable decode
//   err       : last decision was an illegal pattern
//   update    : one-cycle pulse after every decision
//   err_count : saturating count of illegal decisions
//
// Optional feature (macro SEG7_DEC_DP_EN)
//   Adds the following ports:
//     dp_in  : active-low decimal point, part of the settling candidate
//     dp_out : active-high decimal point; latched on legal and blank
//              decisions, held on illegal ones
module seg7_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       hex_in,
    input  logic             sample_en,
`ifdef SEG7_DEC_DP_EN
    input  logic             dp_in,
    output logic             dp_out,
`endif
    output logic [3:0]       value,
    output logic             valid,
    output logic             err,
    output logic             update,
    output logic [ERR_W-1:0] err_count
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
`ifdef SEG7_DEC_DP_EN
    localparam int CAND_W = 8;
`else
    localparam int CAND_W = 7;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2,
        ERROR  = 2'd3
    } state_t;

    // Returns {legal, digit}
    function automatic logic [4:0] decode7(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h40:   r = {1'b1, 4'h0};
            7'h79:   r = {1'b1, 4'h1};
            7'h24:   r = {1'b1, 4'h2};
            7'h30:   r = {1'b1, 4'h3};
            7'h19:   r = {1'b1, 4'h4};
            7'h12:   r = {1'b1, 4'h5};
            7'h02:   r = {1'b1, 4'h6};
            7'h78:   r = {1'b1, 4'h7};
            7'h00:   r = {1'b1, 4'h8};
            7'h10:   r = {1'b1, 4'h9};
            7'h08:   r = {1'b1, 4'hA};
            7'h03:   r = {1'b1, 4'hB};
            7'h46:   r = {1'b1, 4'hC};
            7'h21:   r = {1'b1, 4'hD};
            7'h06:   r = {1'b1, 4'hE};
            7'h0E:   r = {1'b1, 4'hF};
            default: r = 5'b0_0000;
        endcase
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [CAND_W-1:0]  cand_q, cand_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         value_q, value_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               update_q, update_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
`ifdef SEG7_DEC_DP_EN
    logic               dp_q, dp_d;
`endif

    logic [CAND_W-1:0]  sample;
    logic [CNT_W-1:0]   run_len;
    logic               in_run;
    logic               decide;
    logic [4:0]         dec;

`ifdef SEG7_DEC_DP_EN
    assign sample = {dp_in, hex_in};
`else
    assign sample = hex_in;
`endif

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        value_d     = value_q;
        valid_d     = valid_q;
        err_d       = err_q;
        update_d    = 1'b0;
        err_count_d = err_count_q;
`ifdef SEG7_DEC_DP_EN
        dp_d        = dp_q;
`endif
        run_len     = '0;
        in_run      = 1'b0;
        decide      = 1'b0;
        dec         = decode7(cand_q[6:0]);

        if (sample_en) begin
            if (sample != cand_q) begin
                // A new pattern restarts the run from any state; with
                // STABLE_CYCLES=1 this same sample already completes it.
                cand_d  = sample;
                state_d = SETTLE;
                run_len = CNT_W'(1);
                in_run  = 1'b1;
            end else if (state_q == SETTLE) begin
                run_len = cnt_q + CNT_W'(1);
                in_run  = 1'b1;
            end

            if (in_run) begin
                cnt_d  = run_len;
                decide = (run_len == CNT_MAX);
            end
        end

        if (decide) begin
            update_d = 1'b1;
            dec      = decode7(cand_d[6:0]);
            if (cand_d[6:0] == 7'h7F) begin
                valid_d = 1'b0;
                err_d   = 1'b0;
                state_d = IDLE;
`ifdef SEG7_DEC_DP_EN
                dp_d    = ~cand_d[7];
`endif
            end else if (dec[4]) begin
                value_d = dec[3:0];
                valid_d = 1'b1;
                err_d   = 1'b0;
                state_d = LOCKED;
`ifdef SEG7_DEC_DP_EN
                dp_d    = ~cand_d[7];
`endif
            end else begin
                valid_d = 1'b0;
                err_d   = 1'b1;
                state_d = ERROR;
                if (err_count_q != '1) begin
                    err_count_d = err_count_q + ERR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cand_q      <= '1;
            cnt_q       <= '0;
            value_q     <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            update_q    <= 1'b0;
            err_count_q <= '0;
`ifdef SEG7_DEC_DP_EN
            dp_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            value_q     <= value_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            update_q    <= update_d;
            err_count_q <= err_count_d;
`ifdef SEG7_DEC_DP_EN
            dp_q        <= dp_d;
`endif
        end
    end

    assign value     = value_q;
    assign valid     = valid_q;
    assign err       = err_q;
    assign update    = update_q;
    assign err_count = err_count_q;
`ifdef SEG7_DEC_DP_EN
    assign dp_out    = dp_q;
`endif

endmodule
